// File: rtl/if_stage_if.sv
// Fetch-stage bundle: decode-side control/instruction outputs and the
// instruction-memory req/ack port. master = fetch stage, slave = its environment.
interface if_stage_if;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [7:0]  br_target;
  logic [7:0]  lr;
  logic        im_req;
  logic [7:0]  im_addr;
  logic        im_ack;
  logic [7:0]  im_data;
  logic        ins_valid;
  logic [15:0] ins_word;
  logic [7:0]  ins_pc;
  logic [7:0]  seq_pc;

  modport master (
    input  pc_en, pc_sel, br_target, lr, im_ack, im_data,
    output im_req, im_addr, ins_valid, ins_word, ins_pc, seq_pc
  );

  modport slave (
    output pc_en, pc_sel, br_target, lr, im_ack, im_data,
    input  im_req, im_addr, ins_valid, ins_word, ins_pc, seq_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: walks the PC, pulls one or two bytes per instruction
// from instruction memory and holds the assembled word until decode takes it.
module if_stage #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);

    typedef enum logic [1:0] {FETCH_OP, FETCH_IMM, HOLD} state_t;

    state_t     state, state_nxt;
    logic [7:0] pc, pc_nxt;
    logic       redir, two_byte;
    logic       ld_op, ld_imm, set_vld, clr_vld;

    assign redir    = (bus.pc_sel == 2'b01) || (bus.pc_sel == 2'b10);
    assign two_byte = bus.im_data[7:4] inside {4'h9, 4'ha, 4'hb, 4'hf};

    // Request is gated by reset so it drops the moment reset asserts.
    assign bus.im_req  = rst && (state != HOLD);
    assign bus.im_addr = pc;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ld_op     = 1'b0;
        ld_imm    = 1'b0;
        set_vld   = 1'b0;
        clr_vld   = 1'b0;
        if (redir) begin
            pc_nxt    = bus.pc_sel[0] ? bus.br_target : bus.lr;
            state_nxt = FETCH_OP;
            clr_vld   = 1'b1;
        end else begin
            case (state)
                FETCH_OP: if (bus.im_ack) begin
                    pc_nxt    = pc + 8'd1;
                    ld_op     = 1'b1;
                    set_vld   = !two_byte;
                    state_nxt = two_byte ? FETCH_IMM : HOLD;
                end
                FETCH_IMM: if (bus.im_ack) begin
                    pc_nxt    = pc + 8'd1;
                    ld_imm    = 1'b1;
                    set_vld   = 1'b1;
                    state_nxt = HOLD;
                end
                HOLD: if (bus.pc_en) begin
                    clr_vld   = 1'b1;
                    state_nxt = FETCH_OP;
                end
                default: state_nxt = FETCH_OP;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FETCH_OP;
            pc            <= RESET_PC;
            bus.ins_valid <= 1'b0;
            bus.ins_word  <= 16'h0000;
            bus.ins_pc    <= 8'h00;
            bus.seq_pc    <= 8'h00;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            // seq_pc tracks the advancing PC; it is only observed once the word is valid.
            if (ld_op) begin
                bus.ins_word <= {8'h00, bus.im_data};
                bus.ins_pc   <= pc;
                bus.seq_pc   <= pc_nxt;
            end
            if (ld_imm) begin
                bus.ins_word[15:8] <= bus.im_data;
                bus.seq_pc         <= pc_nxt;
            end
            if (set_vld)      bus.ins_valid <= 1'b1;
            else if (clr_vld) bus.ins_valid <= 1'b0;
        end
    end

endmodule
